param_counter: RTL and testbench



---
 rtl/param_counter_if.sv | 24 ++
 rtl/param_counter.sv | 70 +++++++
 tb/tb_param_counter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/param_counter_if.sv
// Control/status bundle for one param_counter channel.
// The master drives the controls; the counter (slave) returns count, terminal and wrap.
interface param_counter_if #(
    parameter int WIDTH = 4
) ();
    logic             enable;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             up;
    logic [WIDTH-1:0] count;
    logic             terminal;
    logic             wrap;

    modport master (
        output enable, clear, load, load_value, up,
        input  count, terminal, wrap
    );

    modport slave (
        input  enable, clear, load, load_value, up,
        output count, terminal, wrap
    );
endinterface

// File: rtl/param_counter.sv
// Parametrised up/down counter with clear, clamped load, terminal flag and registered wrap pulse.
// Define PARAM_COUNTER_SATURATE_EN to make the count hold at its bound instead of wrapping.
module param_counter #(
    parameter int WIDTH       = 4,
    parameter int MAX_COUNT   = 2**WIDTH-1,
    parameter int RESET_VALUE = 0
) (
    input logic           clock,
    input logic           reset,
    param_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [WIDTH-1:0] count_p1;
    logic             wrap_p1;
    logic [WIDTH-1:0] count_d;
    logic             wrap_d;
    logic             at_bound;

    // Out-of-range load values saturate to the top of the modulus.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_V) ? MAX_V : v;
    endfunction

    function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] c,
                                                     input logic             dir_up);
        return dir_up ? (c + ONE_V) : (c - ONE_V);
    endfunction

    assign at_bound = (bus.up && (count_p1 == MAX_V)) || (!bus.up && (count_p1 == '0));

    always_comb begin
        count_d = count_p1;
        wrap_d  = 1'b0;
        if (bus.clear) begin
            count_d = RST_V;
        end else if (bus.load) begin
            count_d = clamp_load(bus.load_value);
        end else if (bus.enable) begin
            if (at_bound) begin
`ifdef PARAM_COUNTER_SATURATE_EN
                count_d = count_p1;
`else
                // Wrap compares against MAX_COUNT, so non-power-of-two moduli close correctly.
                count_d = bus.up ? '0 : MAX_V;
                wrap_d  = 1'b1;
`endif
            end else begin
                count_d = step_count(count_p1, bus.up);
            end
        end
    end

    // Stage p1: registered count and wrap pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_p1 <= RST_V;
            wrap_p1  <= 1'b0;
        end else begin
            count_p1 <= count_d;
            wrap_p1  <= wrap_d;
        end
    end

    assign bus.count    = count_p1;
    assign bus.wrap     = wrap_p1;
    assign bus.terminal = at_bound;
endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench for param_counter (WIDTH=4, MAX_COUNT=9): directed plan steps plus random traffic.
module tb_param_counter;
    localparam int MAXC = 9;
    localparam int RV   = 0;

    logic clock = 1'b0;
    logic reset;

    param_counter_if #(.WIDTH(4)) bus ();

    param_counter #(.WIDTH(4), .MAX_COUNT(MAXC), .RESET_VALUE(RV)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] c;
        logic       w;
        logic       u;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;
    int   mcount = RV;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: apply one cycle of stimulus and queue the expected post-edge state.
    task automatic step(input bit en, input bit clr, input bit ld, input int lv, input bit u);
        bit mwrap;
        @(negedge clock);
        bus.enable     = en;
        bus.clear      = clr;
        bus.load       = ld;
        bus.load_value = 4'(lv);
        bus.up         = u;
        mwrap = 1'b0;
        if (clr) mcount = RV;
        else if (ld) mcount = (lv > MAXC) ? MAXC : lv;
        else if (en) begin
            if (u && mcount == MAXC) begin
`ifndef PARAM_COUNTER_SATURATE_EN
                mcount = 0;
                mwrap  = 1'b1;
`endif
            end else if (!u && mcount == 0) begin
`ifndef PARAM_COUNTER_SATURATE_EN
                mcount = MAXC;
                mwrap  = 1'b1;
`endif
            end else begin
                mcount = u ? mcount + 1 : mcount - 1;
            end
        end
        q.push_back('{c: 4'(mcount), w: mwrap, u: u});
    endtask

    // Monitor: compare the DUT just after each active edge against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("count", int'(bus.count), int'(e.c));
                check("wrap", int'(bus.wrap), int'(e.w));
                check("terminal", int'(bus.terminal),
                      int'((e.u && e.c == 4'(MAXC)) || (!e.u && e.c == 4'd0)));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0; bus.clear = 1'b0; bus.load = 1'b0;
        bus.load_value = '0; bus.up = 1'b1;
        #3;
        check("reset_count", int'(bus.count), RV);
        check("reset_wrap", int'(bus.wrap), 0);
        check("reset_terminal_up", int'(bus.terminal), 0);
        bus.up = 1'b0;
        #1;
        check("reset_terminal_down", int'(bus.terminal), 1);
        bus.up = 1'b1;
        @(negedge clock);
        reset = 1'b0;

        // Count up through a wrap, then down through a wrap.
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        // Clamped load beats enable; clear beats load.
        step(1, 0, 1, 13, 1);
        step(1, 1, 1, 5, 1);
        step(0, 0, 1, 15, 1);
        step(1, 0, 0, 0, 1);
        // Load 7 and count up past the top (saturate build holds at 9).
        step(0, 0, 1, 7, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        // Hold at 4 for 20 cycles while up toggles.
        step(0, 0, 1, 4, 1);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, i[0]);
        step(0, 0, 1, 9, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);

        // Asynchronous reset between edges at count=6.
        step(0, 0, 1, 6, 1);
        step(0, 0, 0, 0, 1);
        @(posedge clock);
        #3;
        check("pre_reset_count", int'(bus.count), 6);
        reset = 1'b1;
        #1;
        check("async_reset_count", int'(bus.count), RV);
        check("async_reset_wrap", int'(bus.wrap), 0);
        bus.enable = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("held_reset_count", int'(bus.count), RV);
        end
        mcount = RV;
        reset = 1'b0;
        bus.enable = 1'b0;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            int r;
            bit en, clr, ld, u;
            r   = $urandom_range(0, 99);
            clr = (r < 4);
            ld  = (r >= 4 && r < 14);
            en  = ($urandom_range(0, 99) < 75);
            u   = ($urandom_range(0, 99) < 60);
            step(en, clr, ld, $urandom_range(0, 15), u);
        end
        step(0, 0, 0, 0, 1);

        for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clock);
        #2;
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
